free_block_arbiter: RTL and testbench

//  Shares the single block-free port (free_block/free_req/free_ack) of the trigger block buffer among
//  NUM_REQ requesters: IRS readout processor, history-buffer drain, software free path.

---
 rtl/free_block_arbiter_pkg.sv | 27 ++
 rtl/free_block_arbiter_rr_priority_select.sv | 41 ++++
 rtl/free_block_arbiter.sv | 147 ++++++++++++++
 tb/tb_free_block_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/free_block_arbiter_pkg.sv
// Shared types and width helpers for the free-block arbiter and its round-robin selector.
package free_block_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    localparam int DEFAULT_ACK_TIMEOUT = 255;
    localparam int TIMER_BITS          = 8;

    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

    // A single requester still needs a one-bit grant index.
    function automatic int grant_bits(input int num_req);
        return (num_req > 1) ? clogb2(num_req - 1) : 1;
    endfunction

endpackage

// File: rtl/free_block_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set bit of pending_i strictly after last_i, wrapping,
// with last_i itself considered last.
module free_block_arbiter_rr_priority_select
    import free_block_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int GW     = grant_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [GW-1:0]      last_i,
    output logic [GW-1:0]      grant_o,
    output logic               valid_o
);

    localparam int SW = GW + 1;

    logic [SW-1:0]      start_w;
    logic [SW-1:0]      sum_w;
    logic [NUM_REQ-1:0] rot_w;
    logic [NUM_REQ:0]   seen_w;
    logic [GW-1:0]      off_acc [NUM_REQ+1];

    // Rotate so bit 0 of rot_w is the requester right after last_i.
    assign start_w = {1'b0, last_i} + SW'(1);
    assign rot_w   = NUM_REQ'({pending_i, pending_i} >> start_w);

    assign seen_w[0]  = 1'b0;
    assign off_acc[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pick
            assign seen_w[gi+1]  = seen_w[gi] | rot_w[gi];
            assign off_acc[gi+1] = off_acc[gi] | ((rot_w[gi] & ~seen_w[gi]) ? GW'(gi) : '0);
        end
    endgenerate

    assign sum_w   = start_w + {1'b0, off_acc[NUM_REQ]};
    assign grant_o = GW'((sum_w >= SW'(NUM_REQ)) ? (sum_w - SW'(NUM_REQ)) : sum_w);
    assign valid_o = seen_w[NUM_REQ];

endmodule

// File: rtl/free_block_arbiter.sv
// Shares the buffer's single block-free port among NUM_REQ requesters: one latched free per
// requester, round-robin grant, req/ack handshake with timeout, sticky overrun/timeout flags.
module free_block_arbiter
    import free_block_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_BITS   = 9,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_block_i,
    input  logic [NUM_REQ-1:0]             req_strobe_i,
    output logic [NUM_REQ-1:0]             req_busy_o,
    output logic [NUM_REQ-1:0]             req_done_o,
    output logic [ADDR_BITS-1:0]           free_block_o,
    output logic                           free_req_o,
    input  logic                           free_ack_i,
    output logic [NUM_REQ-1:0]             overrun_o,
    output logic                           timeout_o,
    input  logic                           err_clr_i
);

    localparam int GW = grant_bits(NUM_REQ);

    state_e                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_q, last_d;
    logic [TIMER_BITS-1:0]  timer_q, timer_d;
    logic [NUM_REQ-1:0]     pending_q, pending_d;
    logic [ADDR_BITS-1:0]   addr_q [NUM_REQ];
    logic [ADDR_BITS-1:0]   addr_d [NUM_REQ];
    logic [ADDR_BITS-1:0]   free_block_q, free_block_d;
    logic                   free_req_q, free_req_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [NUM_REQ-1:0]     overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_REQ-1:0]     clear_w;
    logic                   timeout_set_w;
    logic [GW-1:0]          sel_grant_w;
    logic                   sel_valid_w;

    free_block_arbiter_rr_priority_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .pending_i (pending_q),
        .last_i    (last_q),
        .grant_o   (sel_grant_w),
        .valid_o   (sel_valid_w)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        timer_d       = timer_q;
        free_block_d  = free_block_q;
        free_req_d    = 1'b0;
        done_d        = '0;
        clear_w       = '0;
        timeout_set_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid_w) begin
                    grant_d      = sel_grant_w;
                    free_block_d = addr_q[sel_grant_w];
                    free_req_d   = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (free_ack_i) begin
                    clear_w[grant_q] = 1'b1;
                    done_d[grant_q]  = 1'b1;
                    last_d           = grant_q;
                    state_d          = ST_IDLE;
                end else if (timer_q == TIMER_BITS'(ACK_TIMEOUT)) begin
                    // Abandon the free: the requester is released without a done pulse.
                    clear_w[grant_q] = 1'b1;
                    timeout_set_w    = 1'b1;
                    last_d           = grant_q;
                    state_d          = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_BITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A strobe landing in the cycle its pending entry clears is accepted, not an overrun.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic load_w;
            assign load_w         = req_strobe_i[gi] & (~pending_q[gi] | clear_w[gi]);
            assign pending_d[gi]  = req_strobe_i[gi] | (pending_q[gi] & ~clear_w[gi]);
            assign addr_d[gi]     = load_w ? req_block_i[gi*ADDR_BITS +: ADDR_BITS] : addr_q[gi];
            assign overrun_d[gi]  = (overrun_q[gi] & ~err_clr_i)
                                  | (req_strobe_i[gi] & pending_q[gi] & ~clear_w[gi]);
        end
    endgenerate

    assign timeout_d = (timeout_q & ~err_clr_i) | timeout_set_w;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_q       <= GW'(NUM_REQ - 1);
            timer_q      <= '0;
            pending_q    <= '0;
            free_block_q <= '0;
            free_req_q   <= 1'b0;
            done_q       <= '0;
            overrun_q    <= '0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            free_block_q <= free_block_d;
            free_req_q   <= free_req_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            addr_q       <= addr_d;
        end
    end

    assign req_busy_o   = pending_q;
    assign req_done_o   = done_q;
    assign free_block_o = free_block_q;
    assign free_req_o   = free_req_q;
    assign overrun_o    = overrun_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_free_block_arbiter.sv
// Bench for free_block_arbiter: cycle table, directed corner sequences, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_free_block_arbiter;

    localparam int NR = 2;
    localparam int AB = 9;
    localparam int TO = 255;

    typedef logic [0:0] idx_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NR*AB-1:0]  req_block_i;
    logic [NR-1:0]     req_strobe_i;
    logic [NR-1:0]     req_busy_o;
    logic [NR-1:0]     req_done_o;
    logic [AB-1:0]     free_block_o;
    logic              free_req_o;
    logic              free_ack_i;
    logic [NR-1:0]     overrun_o;
    logic              timeout_o;
    logic              err_clr_i;

    always #5 clk_i = ~clk_i;

    free_block_arbiter #(
        .NUM_REQ     (NR),
        .ADDR_BITS   (AB),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_block_i  (req_block_i),
        .req_strobe_i (req_strobe_i),
        .req_busy_o   (req_busy_o),
        .req_done_o   (req_done_o),
        .free_block_o (free_block_o),
        .free_req_o   (free_req_o),
        .free_ack_i   (free_ack_i),
        .overrun_o    (overrun_o),
        .timeout_o    (timeout_o),
        .err_clr_i    (err_clr_i)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: handshake phase (0 idle, 1 issuing, 2 awaiting ack) plus per-requester slots.
    int            m_phase;
    int            m_wait;
    idx_t          m_last;
    idx_t          m_grant;
    bit [NR-1:0]   m_pend;
    logic [AB-1:0] m_addr [NR];
    logic [AB-1:0] m_blk;
    bit            m_req;
    bit [NR-1:0]   m_done;
    bit [NR-1:0]   m_over;
    bit            m_to;

    task automatic model_step();
        int clear_r;
        if (rst_i) begin
            m_phase = 0; m_wait = 0; m_last = idx_t'(NR - 1); m_grant = '0;
            m_pend = '0; m_blk = '0; m_req = 1'b0; m_done = '0; m_over = '0; m_to = 1'b0;
            for (int r = 0; r < NR; r++) m_addr[idx_t'(r)] = '0;
            return;
        end
        clear_r = -1;
        m_req   = 1'b0;
        m_done  = '0;
        if (err_clr_i) begin
            m_over = '0;
            m_to   = 1'b0;
        end
        if (m_phase == 2) begin
            if (free_ack_i) begin
                clear_r = int'(m_grant); m_done[m_grant] = 1'b1; m_last = m_grant; m_phase = 0;
            end else if (m_wait == TO) begin
                clear_r = int'(m_grant); m_to = 1'b1; m_last = m_grant; m_phase = 0;
            end else begin
                m_wait++;
            end
        end else if (m_phase == 1) begin
            m_wait  = 0;
            m_phase = 2;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                int r;
                r = (int'(m_last) + k) % NR;
                if (m_phase == 0 && m_pend[idx_t'(r)]) begin
                    m_grant = idx_t'(r);
                    m_blk   = m_addr[idx_t'(r)];
                    m_req   = 1'b1;
                    m_phase = 1;
                end
            end
        end
        for (int r = 0; r < NR; r++) begin
            if (req_strobe_i[idx_t'(r)]) begin
                if (m_pend[idx_t'(r)] && r != clear_r) begin
                    m_over[idx_t'(r)] = 1'b1;
                end else begin
                    m_pend[idx_t'(r)] = 1'b1;
                    m_addr[idx_t'(r)] = req_block_i[r*AB +: AB];
                end
            end else if (r == clear_r) begin
                m_pend[idx_t'(r)] = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        n_cmp++;
        if ({req_busy_o, req_done_o, free_req_o, free_block_o, overrun_o, timeout_o} !==
            {m_pend, m_done, m_req, m_blk, m_over, m_to}) begin
            n_err++;
            $display("FAIL model cyc%0d: got busy=%b done=%b req=%b blk=%h ovr=%b to=%b, expected busy=%b done=%b req=%b blk=%h ovr=%b to=%b",
                     cyc, req_busy_o, req_done_o, free_req_o, free_block_o, overrun_o, timeout_o,
                     m_pend, m_done, m_req, m_blk, m_over, m_to);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
        cyc++;
        check_model();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic idle_inputs();
        rst_i = 1'b0; req_strobe_i = '0; free_ack_i = 1'b0; err_clr_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic strobe(input int r, input logic [AB-1:0] blk);
        req_strobe_i[idx_t'(r)] = 1'b1;
        req_block_i[r*AB +: AB] = blk;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 10; i++) begin
            if (free_req_o === 1'b1) return;
            tick();
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: free_req_o never rose within 10 cycles", name);
    endtask

    typedef struct {
        bit        rst;
        bit [1:0]  stb;
        bit [8:0]  b0;
        bit [8:0]  b1;
        bit        ack;
        bit [1:0]  busy;
        bit [1:0]  done;
        bit        req;
        bit [8:0]  blk;
    } vec_t;

    vec_t vecs [16];

    initial begin
        req_block_i = '0;
        idle_inputs();

        // Single free then round-robin pair, one row per cycle; expectations are post-edge.
        vecs[0]  = '{1'b1, 2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b00, 1'b0, 9'h000};
        vecs[1]  = '{1'b0, 2'b01, 9'h1A5, 9'h000, 1'b0, 2'b01, 2'b00, 1'b0, 9'h000};
        vecs[2]  = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b0, 2'b01, 2'b00, 1'b1, 9'h1A5};
        vecs[3]  = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b0, 2'b01, 2'b00, 1'b0, 9'h1A5};
        vecs[4]  = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b0, 2'b01, 2'b00, 1'b0, 9'h1A5};
        vecs[5]  = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b1, 2'b00, 2'b01, 1'b0, 9'h1A5};
        vecs[6]  = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b00, 1'b0, 9'h1A5};
        vecs[7]  = '{1'b1, 2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b00, 1'b0, 9'h000};
        vecs[8]  = '{1'b0, 2'b11, 9'h010, 9'h020, 1'b0, 2'b11, 2'b00, 1'b0, 9'h000};
        vecs[9]  = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b0, 2'b11, 2'b00, 1'b1, 9'h010};
        vecs[10] = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b0, 2'b11, 2'b00, 1'b0, 9'h010};
        vecs[11] = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b1, 2'b10, 2'b01, 1'b0, 9'h010};
        vecs[12] = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b0, 2'b10, 2'b00, 1'b1, 9'h020};
        vecs[13] = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b0, 2'b10, 2'b00, 1'b0, 9'h020};
        vecs[14] = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b1, 2'b00, 2'b10, 1'b0, 9'h020};
        vecs[15] = '{1'b0, 2'b00, 9'h000, 9'h000, 1'b0, 2'b00, 2'b00, 1'b0, 9'h020};

        for (int i = 0; i < 16; i++) begin
            vec_t v;
            v = vecs[4'(i)];
            rst_i        = v.rst;
            req_strobe_i = v.stb;
            req_block_i  = {v.b1, v.b0};
            free_ack_i   = v.ack;
            err_clr_i    = 1'b0;
            tick();
            chk($sformatf("vec%0d busy", i), 32'(req_busy_o), 32'(v.busy));
            chk($sformatf("vec%0d done", i), 32'(req_done_o), 32'(v.done));
            chk($sformatf("vec%0d req", i), 32'(free_req_o), 32'(v.req));
            chk($sformatf("vec%0d blk", i), 32'(free_block_o), 32'(v.blk));
        end
        idle_inputs();

        // Round-robin fairness: both request every iteration, grant order must alternate 0 then 1.
        for (int it = 0; it < 100; it++) begin
            strobe(0, 9'h010); strobe(1, 9'h020);
            tick();
            idle_inputs();
            wait_req("rr first");
            if (free_block_o !== 9'h010) chk($sformatf("rr%0d first blk", it), 32'(free_block_o), 32'h010);
            tick(); free_ack_i = 1'b1; tick(); free_ack_i = 1'b0;
            wait_req("rr second");
            if (free_block_o !== 9'h020) chk($sformatf("rr%0d second blk", it), 32'(free_block_o), 32'h020);
            tick(); free_ack_i = 1'b1; tick(); free_ack_i = 1'b0;
        end
        chk("rr final busy", 32'(req_busy_o), 32'h0);

        // Overrun: second strobe while pending is dropped.
        do_reset();
        strobe(1, 9'h055); tick(); idle_inputs();
        strobe(1, 9'h066); tick(); idle_inputs();
        chk("ovr flag", 32'(overrun_o), 32'h2);
        wait_req("ovr issue");
        chk("ovr blk", 32'(free_block_o), 32'h055);
        tick(); free_ack_i = 1'b1; tick(); free_ack_i = 1'b0;
        chk("ovr done", 32'(req_done_o), 32'h2);
        chk("ovr busy", 32'(req_busy_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ovr no reissue", 32'(free_req_o), 32'h0);
        end
        err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
        chk("ovr cleared", 32'(overrun_o), 32'h0);

        // Timeout: no ack for requester 0, requester 1 waits behind it.
        do_reset();
        strobe(0, 9'h0AA); strobe(1, 9'h0BB); tick(); idle_inputs();
        wait_req("to issue");
        chk("to blk", 32'(free_block_o), 32'h0AA);
        for (int i = 0; i < TO + 1; i++) tick();
        chk("to not yet", 32'(timeout_o), 32'h0);
        tick();
        chk("to flag", 32'(timeout_o), 32'h1);
        chk("to busy", 32'(req_busy_o), 32'h2);
        chk("to no done", 32'(req_done_o), 32'h0);
        tick();
        chk("to next req", 32'(free_req_o), 32'h1);
        chk("to next blk", 32'(free_block_o), 32'h0BB);
        tick(); free_ack_i = 1'b1; tick(); free_ack_i = 1'b0;
        chk("to next done", 32'(req_done_o), 32'h2);
        err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
        chk("to cleared", 32'(timeout_o), 32'h0);

        // Strobe in own done cycle, then a stray ack while idle.
        do_reset();
        strobe(0, 9'h111); tick(); idle_inputs();
        wait_req("bnd issue");
        tick();
        free_ack_i = 1'b1; strobe(0, 9'h122); tick(); idle_inputs();
        chk("bnd done", 32'(req_done_o), 32'h1);
        chk("bnd relatched", 32'(req_busy_o), 32'h1);
        chk("bnd no ovr", 32'(overrun_o), 32'h0);
        tick();
        chk("bnd reissue", 32'(free_req_o), 32'h1);
        chk("bnd reissue blk", 32'(free_block_o), 32'h122);
        tick(); free_ack_i = 1'b1; tick(); free_ack_i = 1'b0;
        tick();
        free_ack_i = 1'b1; tick(); free_ack_i = 1'b0;
        chk("stray done", 32'(req_done_o), 32'h0);
        chk("stray flags", 32'({overrun_o, timeout_o, free_req_o}), 32'h0);

        // Reset during WAIT_ACK, late ack, then a fresh request.
        do_reset();
        strobe(1, 9'h1C3); tick(); idle_inputs();
        wait_req("rst issue");
        tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("rst outputs", 32'({req_busy_o, req_done_o, free_req_o, free_block_o, overrun_o, timeout_o}), 32'h0);
        free_ack_i = 1'b1; tick(); free_ack_i = 1'b0;
        chk("rst late ack", 32'({req_done_o, free_req_o}), 32'h0);
        strobe(0, 9'h0F0); tick(); idle_inputs();
        wait_req("rst fresh");
        chk("rst fresh blk", 32'(free_block_o), 32'h0F0);
        tick(); free_ack_i = 1'b1; tick(); free_ack_i = 1'b0;
        chk("rst fresh done", 32'(req_done_o), 32'h1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            idle_inputs();
            for (int r = 0; r < NR; r++) begin
                if ($urandom_range(5) == 0) strobe(r, AB'($urandom));
            end
            free_ack_i = ($urandom_range(3) == 0);
            err_clr_i  = ($urandom_range(29) == 0);
            rst_i      = ($urandom_range(499) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
